mod_counter: RTL and testbench

- Parametrised successor to the team's 8-bit up-counter.
- Adds: configurable width, up/down direction, programmable terminal value (modulo), parallel load, wrap or saturate mode, and registered overflow/underflow event and sticky flags.
- Used as a general event/timebase counter in peripheral blocks.
- Single clock domain, all outputs registered except the `tc` decode.

---
 rtl/mod_counter_pkg.sv | 34 +++
 rtl/mod_counter_if.sv | 37 +++
 rtl/mod_counter_prescaler.sv | 27 ++
 rtl/mod_counter.sv | 81 ++++++++
 tb/tb_mod_counter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg
//   Shared definitions for the mod_counter block: terminal-mode encodings
//   and the next-count function used by the counter datapath.
//   Optional feature macro used by this slice: COUNTER_PRESCALE_EN.
package mod_counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Widest counter the helper supports; callers zero-extend their count
    // into this type and truncate the result back to their own width.
    localparam int CNT_MAX_W = 64;
    typedef logic [CNT_MAX_W-1:0] cnt_word_t;

    // Next count for one step. An up-step only increments while below
    // max_val and a down-step only decrements above zero, so the result
    // never exceeds max(count, max_val) and truncation to the caller's
    // width is lossless.
    function automatic cnt_word_t next_count(input cnt_word_t count,
                                             input cnt_word_t max_val,
                                             input logic      up_dn,
                                             input int        mode);
        cnt_word_t res;
        if (up_dn) begin
            if (count >= max_val) res = (mode == MODE_SAT) ? count : '0;
            else                  res = count + 1'b1;
        end else begin
            if (count == '0)      res = (mode == MODE_SAT) ? '0 : max_val;
            else                  res = count - 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mod_counter_if.sv
// mod_counter_if
//   Control/status bundle of mod_counter.
//   master : driver of the counter (count_en, count_clr, up_dn, load,
//            load_val, max_val, flag_clr, presc_div -> count, tc, evt,
//            ovf_sticky, unf_sticky)
//   slave  : the counter itself.
//   presc_div only matters when COUNTER_PRESCALE_EN is defined.
interface mod_counter_if #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
);
    logic               count_en;
    logic               count_clr;
    logic               up_dn;
    logic               load;
    logic [WIDTH-1:0]   load_val;
    logic [WIDTH-1:0]   max_val;
    logic               flag_clr;
    logic [PRESC_W-1:0] presc_div;
    logic [WIDTH-1:0]   count;
    logic               tc;
    logic               evt;
    logic               ovf_sticky;
    logic               unf_sticky;

    modport master (
        output count_en, count_clr, up_dn, load, load_val, max_val,
               flag_clr, presc_div,
        input  count, tc, evt, ovf_sticky, unf_sticky
    );

    modport slave (
        input  count_en, count_clr, up_dn, load, load_val, max_val,
               flag_clr, presc_div,
        output count, tc, evt, ovf_sticky, unf_sticky
    );
endinterface

// File: rtl/mod_counter_prescaler.sv
// counter_prescaler
//   Enable divider for mod_counter: tick is asserted on every (div+1)-th
//   cycle with en=1; the phase holds while en=0 and restarts on clr.
//   Ports: clk, rst_n (async active-low), en, clr, div[PRESC_W] -> tick.
//   Only compiled when COUNTER_PRESCALE_EN is defined.
`ifdef COUNTER_PRESCALE_EN
module counter_prescaler #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] div,
    output logic               tick
);
    logic [PRESC_W-1:0] cnt_q;

    assign tick = en & (cnt_q == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt_q <= '0;
        else if (clr)    cnt_q <= '0;
        else if (en)     cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
endmodule
`endif

// File: rtl/mod_counter.sv
// mod_counter
//   Parametrised up/down modulo counter with load, wrap/saturate terminal
//   behaviour and registered terminal event / sticky over/underflow flags.
//   Ports: clk, rst_n (async active-low), bus (mod_counter_if.slave):
//     count_en, count_clr, up_dn, load, load_val, max_val, flag_clr,
//     presc_div -> count, tc (combinational), evt, ovf_sticky, unf_sticky.
//   Optional prescaler: define COUNTER_PRESCALE_EN.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MODE    = MODE_WRAP,
    parameter int PRESC_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mod_counter_if.slave  bus
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_nxt;
    logic             evt_q;
    logic             ovf_q;
    logic             unf_q;
    logic             tc_int;
    logic             tick;
    logic             step;
    logic             term_step;

`ifdef COUNTER_PRESCALE_EN
    // Load restarts the prescaler phase just like clear.
    counter_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.count_en),
        .clr   (bus.count_clr | bus.load),
        .div   (bus.presc_div),
        .tick  (tick)
    );
`else
    logic unused_presc;
    assign unused_presc = ^bus.presc_div;
    assign tick         = 1'b1;
`endif

    always_comb begin
        tc_int    = bus.up_dn ? (count_q >= bus.max_val) : (count_q == '0);
        step      = bus.count_en & tick & ~bus.load;
        term_step = step & tc_int;
        count_nxt = WIDTH'(next_count(cnt_word_t'(count_q),
                                      cnt_word_t'(bus.max_val),
                                      bus.up_dn, MODE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            evt_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (bus.count_clr) begin
            count_q <= '0;
            evt_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (bus.load)  count_q <= bus.load_val;
            else if (step) count_q <= count_nxt;
            // term_step is already 0 during load, so evt drops there too.
            evt_q <= term_step;
            // A terminal event in the same cycle as flag_clr keeps the flag set.
            ovf_q <= (term_step &  bus.up_dn) | (ovf_q & ~bus.flag_clr);
            unf_q <= (term_step & ~bus.up_dn) | (unf_q & ~bus.flag_clr);
        end
    end

    assign bus.count      = count_q;
    assign bus.tc         = tc_int;
    assign bus.evt        = evt_q;
    assign bus.ovf_sticky = ovf_q;
    assign bus.unf_sticky = unf_q;
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter
//   Self-checking bench for mod_counter: a wrap-mode and a saturate-mode
//   instance share one stimulus stream (directed scenarios, then random)
//   and are compared each cycle against a behavioural reference model.
//   Honours COUNTER_PRESCALE_EN for the prescaler scenario and model.
module tb_mod_counter;
    import mod_counter_pkg::*;

    localparam int W  = 8;
    localparam int PW = 4;

    logic clk;
    logic rst_n;

    mod_counter_if #(.WIDTH(W), .PRESC_W(PW)) bw ();
    mod_counter_if #(.WIDTH(W), .PRESC_W(PW)) bs ();

    mod_counter #(.WIDTH(W), .MODE(MODE_WRAP), .PRESC_W(PW)) dut_wrap (
        .clk (clk), .rst_n (rst_n), .bus (bw.slave)
    );
    mod_counter #(.WIDTH(W), .MODE(MODE_SAT), .PRESC_W(PW)) dut_sat (
        .clk (clk), .rst_n (rst_n), .bus (bs.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stimulus shared by both instances
    bit          s_en, s_clr, s_ud, s_ld, s_fc;
    int unsigned s_lv, s_mx, s_pd;

    // Reference model state, index 0 = wrap, 1 = saturate
    int unsigned m_cnt [2];
    bit          m_evt [2];
    bit          m_ovf [2];
    bit          m_unf [2];
    int unsigned m_psc [2];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic drive();
        bw.count_en = s_en;  bs.count_en = s_en;
        bw.count_clr = s_clr; bs.count_clr = s_clr;
        bw.up_dn = s_ud;     bs.up_dn = s_ud;
        bw.load = s_ld;      bs.load = s_ld;
        bw.load_val = W'(s_lv); bs.load_val = W'(s_lv);
        bw.max_val = W'(s_mx);  bs.max_val = W'(s_mx);
        bw.flag_clr = s_fc;  bs.flag_clr = s_fc;
        bw.presc_div = PW'(s_pd); bs.presc_div = PW'(s_pd);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_evt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0; m_psc[i] = 0;
        end
    endtask

    // One clock edge of the counter rules, written from the behavioural description.
    task automatic model_clock();
        for (int i = 0; i < 2; i++) begin
            bit tick, term;
            tick = 0;
            term = 0;
            if (s_clr) begin
                m_cnt[i] = 0; m_evt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0; m_psc[i] = 0;
            end else if (s_ld) begin
                m_cnt[i] = s_lv;
                m_evt[i] = 0;
                m_psc[i] = 0;
                if (s_fc) begin m_ovf[i] = 0; m_unf[i] = 0; end
            end else begin
                if (s_en) begin
`ifdef COUNTER_PRESCALE_EN
                    if (m_psc[i] == s_pd) begin tick = 1; m_psc[i] = 0; end
                    else m_psc[i] = (m_psc[i] + 1) % (1 << PW);
`else
                    tick = 1;
`endif
                end
                if (tick) begin
                    if (s_ud) begin
                        if (m_cnt[i] >= s_mx) begin
                            term = 1;
                            if (i == 0) m_cnt[i] = 0;
                        end else m_cnt[i] = m_cnt[i] + 1;
                    end else begin
                        if (m_cnt[i] == 0) begin
                            term = 1;
                            if (i == 0) m_cnt[i] = s_mx;
                        end else m_cnt[i] = m_cnt[i] - 1;
                    end
                end
                m_evt[i] = term;
                m_ovf[i] = (term && s_ud)  || (m_ovf[i] && !s_fc);
                m_unf[i] = (term && !s_ud) || (m_unf[i] && !s_fc);
            end
        end
    endtask

    function automatic bit model_tc(input int i);
        return s_ud ? (m_cnt[i] >= s_mx) : (m_cnt[i] == 0);
    endfunction

    task automatic check_regs();
        check("wrap_count", bw.count, m_cnt[0]);
        check("wrap_evt",   bw.evt, m_evt[0]);
        check("wrap_ovf",   bw.ovf_sticky, m_ovf[0]);
        check("wrap_unf",   bw.unf_sticky, m_unf[0]);
        check("sat_count",  bs.count, m_cnt[1]);
        check("sat_evt",    bs.evt, m_evt[1]);
        check("sat_ovf",    bs.ovf_sticky, m_ovf[1]);
        check("sat_unf",    bs.unf_sticky, m_unf[1]);
    endtask

    // Drive current stimulus, check tc before the edge, clock, check registers.
    task automatic step_cycle();
        drive();
        #1;
        check("wrap_tc", bw.tc, model_tc(0));
        check("sat_tc",  bs.tc, model_tc(1));
        @(posedge clk);
        model_clock();
        #1;
        check_regs();
    endtask

    task automatic idle_stim();
        s_en = 0; s_clr = 0; s_ld = 0; s_fc = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        s_en = 0; s_clr = 0; s_ud = 1; s_ld = 0; s_fc = 0;
        s_lv = 0; s_mx = 0; s_pd = 0;
        drive();
        model_reset();
        #1;
        check_regs();
        check("rst_wrap_count", bw.count, 0);
        #1 rst_n = 1'b1;

        // Wrap at max_val=9, counting up from reset
        s_mx = 9; s_ud = 1; s_en = 1;
        repeat (12) step_cycle();
        check("up9_wrap_count", bw.count, 2);
        check("up9_wrap_ovf",   bw.ovf_sticky, 1);
        check("up9_sat_count",  bs.count, 9);

        // Saturating down count from 2 with max_val=5
        idle_stim(); s_clr = 1; step_cycle();
        idle_stim(); s_mx = 5; s_ld = 1; s_lv = 2; step_cycle();
        idle_stim(); s_ud = 0; s_en = 1;
        repeat (4) step_cycle();
        check("dn_sat_count", bs.count, 0);
        check("dn_sat_unf",   bs.unf_sticky, 1);
        check("dn_wrap_count", bw.count, 4);

        // Loaded above max_val: up is terminal, down just decrements
        idle_stim(); s_mx = 100; s_lv = 200; s_ld = 1; step_cycle();
        idle_stim(); s_ud = 1; s_en = 1; step_cycle();
        check("above_up_wrap", bw.count, 0);
        check("above_up_evt",  bw.evt, 1);
        idle_stim(); s_ld = 1; step_cycle();
        idle_stim(); s_ud = 0; s_en = 1; step_cycle();
        check("above_dn_wrap", bw.count, 199);
        check("above_dn_evt",  bw.evt, 0);

        // Clear beats load and step; flag set beats flag_clr
        idle_stim(); s_lv = 7; s_ld = 1; step_cycle();
        idle_stim(); s_clr = 1; s_ld = 1; s_en = 1; s_ud = 1; step_cycle();
        check("clr_prio_count", bw.count, 0);
        check("clr_prio_ovf",   bw.ovf_sticky, 0);
        idle_stim(); s_ud = 0; s_en = 1; s_fc = 1; step_cycle();
        check("setwins_unf", bw.unf_sticky, 1);

        // max_val=0: every step is terminal and the count stays 0
        idle_stim(); s_clr = 1; step_cycle();
        idle_stim(); s_mx = 0; s_en = 1;
        for (int k = 0; k < 6; k++) begin
            s_ud = k[0];
            step_cycle();
        end

        // Async reset between edges
        idle_stim(); s_mx = 255; s_lv = 'h55; s_ld = 1; step_cycle();
        idle_stim(); drive();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_wrap_count", bw.count, 0);
        check("async_sat_count",  bs.count, 0);
        check_regs();
        #1 rst_n = 1'b1;

`ifdef COUNTER_PRESCALE_EN
        // Divide by 4, then a load restarts the phase
        idle_stim(); s_clr = 1; step_cycle();
        idle_stim(); s_mx = 255; s_ud = 1; s_pd = 3; s_en = 1;
        repeat (12) step_cycle();
        check("presc_count", bw.count, 3);
        repeat (2) step_cycle();
        s_ld = 1; s_lv = 10; step_cycle();
        s_ld = 0;
        repeat (8) step_cycle();
        check("presc_load_phase", bw.count, 12);
`endif

        // Random traffic
        s_mx = 15; s_ud = 1; s_pd = 0;
        for (int k = 0; k < 1500; k++) begin
            int unsigned r;
            if ($urandom_range(0, 7) == 0) begin
                r = $urandom_range(0, 9);
                if (r == 0)      s_mx = 0;
                else if (r == 1) s_mx = 255;
                else if (r < 5)  s_mx = $urandom_range(1, 10);
                else             s_mx = $urandom_range(0, 255);
            end
            if ($urandom_range(0, 9) == 0) s_ud = ~s_ud;
            if ($urandom_range(0, 49) == 0) s_pd = $urandom_range(0, 3);
            s_en  = ($urandom_range(0, 3) != 0);
            s_clr = ($urandom_range(0, 59) == 0);
            s_ld  = ($urandom_range(0, 24) == 0);
            s_lv  = $urandom_range(0, 255);
            s_fc  = ($urandom_range(0, 14) == 0);
            step_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
